// File: rtl/reg_file_mp.sv
// Multi-port integer register file with hardwired-zero x0 and a per-register busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module reg_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_DEPTH = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  localparam int AW        = $clog2(ADDR_DEPTH)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_RD*AW-1:0]         rd_addr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data_o,
  output logic [NUM_RD-1:0]            rd_busy_o,
  input  logic [NUM_WR-1:0]            wr_en_i,
  input  logic [NUM_WR*AW-1:0]         wr_addr_i,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data_i,
  input  logic                         set_busy_i,
  input  logic [AW-1:0]                set_addr_i,
  output logic [ADDR_DEPTH-1:0]        busy_vec_o
);

  logic [DATA_WIDTH-1:0] regs [ADDR_DEPTH];
  logic [ADDR_DEPTH-1:0] busy_q;
  logic [ADDR_DEPTH-1:0] busy_nxt;

  // Later loop iterations win, so write port 1 overrides port 0 on a shared address.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ADDR_DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] != '0)) begin
          regs[wr_addr_i[w*AW +: AW]] <= wr_data_i[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      busy_q <= busy_nxt;
    end
  end

  // A newly issued producer supersedes a retiring one, so set is applied after clears.
  always_comb begin
    busy_nxt = busy_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w]) begin
        busy_nxt[wr_addr_i[w*AW +: AW]] = 1'b0;
      end
    end
    if (set_busy_i) begin
      busy_nxt[set_addr_i] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  assign busy_vec_o = busy_q;

  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = regs[rd_addr_i[k*AW +: AW]];
      rd_busy_o[k] = busy_q[rd_addr_i[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] != '0) &&
            (wr_addr_i[w*AW +: AW] == rd_addr_i[k*AW +: AW])) begin
          rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = wr_data_i[w*DATA_WIDTH +: DATA_WIDTH];
          if (!(set_busy_i && (set_addr_i == rd_addr_i[k*AW +: AW]))) begin
            rd_busy_o[k] = 1'b0;
          end
        end
      end
`endif
      if (rd_addr_i[k*AW +: AW] == '0) begin
        rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = '0;
        rd_busy_o[k] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: reset, x0 handling, write priority, read latency/bypass, scoreboard.
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AD = 32;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int AW = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic             set_busy;
  logic [AW-1:0]    set_addr;
  logic [AD-1:0]    busy_vec;

  int total = 0;
  int bad   = 0;

  reg_file_mp #(.DATA_WIDTH(DW), .ADDR_DEPTH(AD), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rd_busy_o  (rd_busy),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .set_busy_i (set_busy),
    .set_addr_i (set_addr),
    .busy_vec_o (busy_vec)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = '0;
    set_busy = 1'b0;
    set_addr = '0;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic wr(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[port] = 1'b1;
    wr_addr[port*AW +: AW] = a;
    wr_data[port*DW +: DW] = d;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; wr_addr = '0; wr_data = '0;
    idle();
    tick();
    rst = 1'b0;

    rd(5'd5, 5'd0);
    check("rst_x5_init", rd_data[DW-1:0], 32'h0);
    check("rst_busy_vec_init", busy_vec, 0);

    // write x5, then reset with a competing write and set_busy in the reset cycle
    wr(0, 5'd5, 32'hDEADBEEF);
    tick();
    idle();
    rd(5'd5, 5'd0);
    check("x5_written", rd_data[DW-1:0], 32'hDEADBEEF);
    rst = 1'b1;
    wr(1, 5'd6, 32'h66);
    set_busy = 1'b1; set_addr = 5'd6;
    tick();
    rst = 1'b0;
    idle();
    rd(5'd5, 5'd6);
    check("rst_x5_cleared", rd_data[DW-1:0], 32'h0);
    check("rst_x6_write_ignored", rd_data[2*DW-1:DW], 32'h0);
    check("rst_busy_vec_clear", busy_vec, 0);

    // x0 is hardwired zero
    wr(0, 5'd0, 32'h12345678);
    set_busy = 1'b1; set_addr = 5'd0;
    rd(5'd0, 5'd0);
    check("x0_same_cycle", rd_data[DW-1:0], 32'h0);
    tick();
    idle();
    rd(5'd0, 5'd0);
    check("x0_after_write", rd_data, 64'h0);
    check("x0_busy_vec", busy_vec, 0);
    check("x0_rd_busy", rd_busy, 2'b00);

    // port 1 wins on same-address writes
    wr(0, 5'd7, 32'h11);
    wr(1, 5'd7, 32'h22);
    tick();
    idle();
    rd(5'd7, 5'd7);
    check("x7_port1_wins", rd_data, {32'h22, 32'h22});

    // write-to-read latency on x3
    wr(0, 5'd3, 32'hA5A5A5A5);
    rd(5'd0, 5'd3);
`ifdef REGFILE_BYPASS_EN
    check("x3_same_cycle", rd_data[2*DW-1:DW], 32'hA5A5A5A5);
`else
    check("x3_same_cycle", rd_data[2*DW-1:DW], 32'h0);
`endif
    tick();
    idle();
    rd(5'd3, 5'd3);
    check("x3_next_cycle", rd_data, {32'hA5A5A5A5, 32'hA5A5A5A5});

    // scoreboard set then clear by port 1
    set_busy = 1'b1; set_addr = 5'd9;
    tick();
    idle();
    rd(5'd9, 5'd7);
    check("busy9_vec", busy_vec, 64'h200);
    check("busy9_rd_busy", rd_busy, 2'b01);
    wr(1, 5'd9, 32'hCAFE);
    rd(5'd9, 5'd7);
`ifdef REGFILE_BYPASS_EN
    check("busy9_clear_same_cycle", rd_busy, 2'b00);
`else
    check("busy9_clear_same_cycle", rd_busy, 2'b01);
`endif
    tick();
    idle();
    rd(5'd9, 5'd9);
    check("busy9_cleared_vec", busy_vec, 0);
    check("x9_data", rd_data, {32'hCAFE, 32'hCAFE});

    // two busy bits, clear only one via port 0
    set_busy = 1'b1; set_addr = 5'd12;
    tick();
    set_addr = 5'd13;
    tick();
    idle();
    check("busy12_13_vec", busy_vec, 64'h3000);
    wr(0, 5'd12, 32'h1);
    tick();
    idle();
    rd(5'd12, 5'd13);
    check("busy13_only", busy_vec, 64'h2000);
    check("busy13_rd_busy", rd_busy, 2'b10);
    wr(0, 5'd13, 32'h2);
    tick();
    idle();

    // set beats same-cycle clear, then reset clears everything
    set_busy = 1'b1; set_addr = 5'd4;
    tick();
    idle();
    check("busy4_set", busy_vec, 64'h10);
    set_busy = 1'b1; set_addr = 5'd4;
    wr(0, 5'd4, 32'h55);
    tick();
    idle();
    rd(5'd4, 5'd0);
    check("x4_written", rd_data[DW-1:0], 32'h55);
    check("busy4_held", busy_vec, 64'h10);
    check("busy4_rd_busy", rd_busy, 2'b01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd(5'd4, 5'd7);
    check("rst2_busy_vec", busy_vec, 0);
    check("rst2_data", rd_data, 64'h0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port integer register file for the pipelined core, replacing the fixed 2R/1W register file.
- Provides NUM_RD combinational read ports and NUM_WR synchronous write ports, with a hardwired-zero x0.
- Contains a per-register busy scoreboard: decode sets a register busy when it issues a writer, and writeback clears it. The core uses this to stall without forwarding logic.
- An optional write-to-read bypass is available through a compile-time macro.

Parameters:
- DATA_WIDTH, 32, width of each register in bits.
- ADDR_DEPTH, 32, number of registers; must be a power of 2, at least 2.
- NUM_RD, 2, number of read ports, 1..4.
- NUM_WR, 2, number of write ports, 1..2. Port 0 is the ALU writeback; port 1 is the load writeback.
- AW is derived internally as $clog2(ADDR_DEPTH). It is a localparam, not overridable.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- rd_addr_i  in  NUM_RD*AW  packed read addresses; port k occupies bits [k*AW +: AW].
- rd_data_o  out  NUM_RD*DATA_WIDTH  packed read data, same packing.
- rd_busy_o  out  NUM_RD  busy flag of the register addressed by each read port.
- wr_en_i  in  NUM_WR  per-port write enable.
- wr_addr_i  in  NUM_WR*AW  packed write addresses.
- wr_data_i  in  NUM_WR*DATA_WIDTH  packed write data.
- set_busy_i  in  1  issue strobe: mark set_addr_i busy.
- set_addr_i  in  AW  register whose pending writer is being issued.
- busy_vec_o  out  ADDR_DEPTH  registered busy bits; bit 0 is always 0.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - All registers become 0; all busy bits become 0.
  - Writes and set_busy in the same cycle are ignored. Reset has priority mid-operation.
  - After the reset edge: rd_data_o=0 for every port, rd_busy_o=0, busy_vec_o=0.
  - No $readmemh initialisation; reset is the only initialiser.
- Reads:
  - Combinational, zero latency: rd_data_o[k] = reg[rd_addr_i[k]], subject to the bypass below.
  - Reading address 0 always returns 0, regardless of bypass or writes.
- Writes:
  - On the rising edge, for each port w with wr_en_i[w]=1 and wr_addr_i[w]!=0, reg[wr_addr_i[w]] <= wr_data_i[w].
  - Writes to address 0 are discarded.
  - Two ports writing the same address in one cycle: the higher port index (port 1) wins.
- Scoreboard, next-state of busy[r] for r != 0, with priority in this order:
  1. rst_i=1 -> 0.
  2. set_busy_i=1 and set_addr_i==r -> 1. Set beats a same-cycle clear, because the new producer supersedes the retiring one.
  3. Any wr_en_i[w]=1 with wr_addr_i[w]==r -> 0.
  4. Otherwise hold.
- busy[0] is constant 0; set_busy_i with set_addr_i=0 has no effect.
- rd_busy_o[k] = busy[rd_addr_i[k]], combinational from registered state. With the bypass macro defined, a same-cycle write to that address clears the reported busy, unless set_busy_i targets the same address in that cycle.
- Latency:
  - Write-to-read is 1 cycle without bypass, 0 cycles with it.
  - set_busy_i-to-busy_vec_o is 1 cycle.
- Out-of-range addresses cannot occur, since ADDR_DEPTH = 2^AW.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Each read port compares rd_addr_i[k] against every enabled write port with a nonzero address.
  - On a match it returns wr_data_i of the highest matching port index in the same cycle (write-through). This removes the WB->ID one-cycle hazard.
  - rd_busy_o is masked as described in Behaviour.
- Undefined:
  - Reads return only stored values, so a same-cycle write is visible the next cycle.
  - rd_busy_o reflects registered busy only.
  - No comparator logic is generated.

Test Plan:
- Reset with rst_i=1 for 1 cycle, having previously written 0xDEADBEEF to x5 -> after the reset edge, reading x5 gives 0 and busy_vec_o=0.
- Port 0 writes x0=0x12345678 -> rd_data_o for x0 stays 0; busy_vec_o[0] stays 0.
- Same cycle: port 0 writes x7=0x11, port 1 writes x7=0x22 -> the next cycle reads x7=0x22.
- Write x3=0xA5A5A5A5 while reading x3 in the same cycle:
  - Without REGFILE_BYPASS_EN -> read shows the old value 0, then 0xA5A5A5A5 the next cycle.
  - With REGFILE_BYPASS_EN -> read shows 0xA5A5A5A5 in the same cycle.
- set_busy_i with set_addr_i=9 -> busy_vec_o[9]=1 and rd_busy_o=1 for a port reading x9. A later port 1 write to x9 -> busy_vec_o[9]=0 the next cycle.
- busy[4]=1; in the same cycle set_busy_i with set_addr_i=4 and port 0 writes x4=0x55 -> x4=0x55 and busy[4] stays 1. Assert rst_i in the following cycle -> busy[4]=0 and x4=0.
